// File: rtl/toll_collect_if.sv
// Lane-side bundle for toll_collect: arrival/rate/coin inputs and payment/gate outputs.
// The master drives arrivals and coins; the slave (the controller) drives status.
interface toll_collect_if;
  logic       VA;
  logic       H;
  logic       M;
  logic       L;
  logic       E;
  logic       COIN;
  logic [1:0] COIN_VAL;
  logic       BUSY;
  logic [7:0] DUE;
  logic       GATE;
  logic [7:0] CHG;
  logic       CHG_V;
  logic       VIOL;

  modport master (
    output VA, H, M, L, E, COIN, COIN_VAL,
    input  BUSY, DUE, GATE, CHG, CHG_V, VIOL
  );

  modport slave (
    input  VA, H, M, L, E, COIN, COIN_VAL,
    output BUSY, DUE, GATE, CHG, CHG_V, VIOL
  );
endinterface

// File: rtl/toll_collect.sv
// Toll lane payment and gate controller: prices an arriving vehicle, collects coins,
// returns change, opens the gate for a fixed time and flags rate or timeout violations.
module toll_collect #(
  parameter int PRICE_H     = 100,
  parameter int PRICE_M     = 75,
  parameter int PRICE_L     = 50,
  parameter int TIMEOUT     = 200,
  parameter int GATE_CYCLES = 16
) (
  input  logic           CLK,
  input  logic           RST,
  toll_collect_if.slave  bus
);

  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam int GATE_W = $clog2(GATE_CYCLES + 1);

  localparam logic [7:0]        P_H       = 8'(PRICE_H);
  localparam logic [7:0]        P_M       = 8'(PRICE_M);
  localparam logic [7:0]        P_L       = 8'(PRICE_L);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAY  = 2'd1,
    S_OPEN = 2'd2
  } state_t;

  state_t            r_state;
  logic [7:0]        r_credit;
  logic [7:0]        r_price;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [GATE_W-1:0] r_gate_cnt;

  logic       r_busy;
  logic [7:0] r_due;
  logic       r_gate;
  logic [7:0] r_chg;
  logic       r_chg_v;
  logic       r_viol;

  logic [7:0] w_coin_val;
  logic [7:0] w_new_credit;
  logic [3:0] w_rate;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_coin_val = 8'd5;
    case (bus.COIN_VAL)
      2'b00:   w_coin_val = 8'd5;
      2'b01:   w_coin_val = 8'd10;
      2'b10:   w_coin_val = 8'd25;
      default: w_coin_val = 8'd100;
    endcase
  end

  // Credit before the last coin is below price (<=155), so the sum stays within 254.
  assign w_new_credit = r_credit + w_coin_val;
  assign w_rate       = {bus.H, bus.M, bus.L, bus.E};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_price    <= '0;
      r_idle_cnt <= '0;
      r_gate_cnt <= '0;
      r_busy     <= 1'b0;
      r_due      <= '0;
      r_gate     <= 1'b0;
      r_chg      <= '0;
      r_chg_v    <= 1'b0;
      r_viol     <= 1'b0;
    end else begin
      r_chg_v <= 1'b0;
      r_viol  <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.VA) begin
            case (w_rate)
              4'b1000: begin
                r_price    <= P_H;
                r_due      <= P_H;
                r_credit   <= '0;
                r_idle_cnt <= '0;
                r_busy     <= 1'b1;
                r_state    <= S_PAY;
              end
              4'b0100: begin
                r_price    <= P_M;
                r_due      <= P_M;
                r_credit   <= '0;
                r_idle_cnt <= '0;
                r_busy     <= 1'b1;
                r_state    <= S_PAY;
              end
              4'b0010: begin
                r_price    <= P_L;
                r_due      <= P_L;
                r_credit   <= '0;
                r_idle_cnt <= '0;
                r_busy     <= 1'b1;
                r_state    <= S_PAY;
              end
              4'b0001: begin
                r_gate_cnt <= '0;
                r_gate     <= 1'b1;
                r_busy     <= 1'b1;
                r_state    <= S_OPEN;
              end
              default: r_viol <= 1'b1;
            endcase
          end
        end

        S_PAY: begin
          // A coin always beats the timeout on the same edge.
          if (bus.COIN) begin
            r_credit   <= w_new_credit;
            r_idle_cnt <= '0;
            if (w_new_credit >= r_price) begin
              r_chg      <= w_new_credit - r_price;
              r_chg_v    <= 1'b1;
              r_due      <= '0;
              r_gate     <= 1'b1;
              r_gate_cnt <= '0;
              r_state    <= S_OPEN;
            end else begin
              r_due <= r_price - w_new_credit;
            end
          end else if (r_idle_cnt == IDLE_LAST) begin
            r_viol <= 1'b1;
            if (r_credit != 8'd0) begin
              r_chg   <= r_credit;
              r_chg_v <= 1'b1;
            end
            r_credit <= '0;
            r_due    <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end

        S_OPEN: begin
          if (r_gate_cnt == GATE_LAST) begin
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY  = r_busy;
  assign bus.DUE   = r_due;
  assign bus.GATE  = r_gate;
  assign bus.CHG   = r_chg;
  assign bus.CHG_V = r_chg_v;
  assign bus.VIOL  = r_viol;

endmodule

// File: doc/toll_collect.md
# toll_collect

Payment and gate controller for the toll lane, downstream of the toll-rate classifier. On each vehicle-arrival strobe it latches the one-hot rate class (H, M, L, E) and prices it. It then accumulates coins until the toll is covered, returns change and opens the gate for a fixed time. It flags a violation on an invalid rate code or a payment timeout.

## Interface

Parameters:
- PRICE_H, 100: high-rate toll in cents; legal range 1..155.
- PRICE_M, 75: medium-rate toll in cents; legal range 1..155.
- PRICE_L, 50: low-rate toll in cents; legal range 1..155.
- TIMEOUT, 200: idle cycles allowed in PAY before a violation; minimum 2.
- GATE_CYCLES, 16: number of cycles GATE stays high; minimum 1.

Ports:
- CLK, in, 1: clock, all logic on rising edge.
- RST, in, 1: reset, synchronous, active-high.
- VA, in, 1: vehicle-arrival strobe; samples H/M/L/E.
- H, M, L, E, in, 1 each: rate class from the classifier; must be one-hot.
- COIN, in, 1: coin-valid strobe, one coin per cycle.
- COIN_VAL, in, 2: coin value; 00 = 5, 01 = 10, 10 = 25, 11 = 100 cents.
- BUSY, out, 1: high in PAY and OPEN.
- DUE, out, 8: cents still owed; 0 outside PAY.
- GATE, out, 1: gate-open command.
- CHG, out, 8: change or refund amount; valid while CHG_V is high.
- CHG_V, out, 1: one-cycle change/refund pulse.
- VIOL, out, 1: one-cycle violation pulse.

## Operation

- States: IDLE, PAY, OPEN.
- Internal registers:
  - `credit`, 8-bit unsigned.
  - `price`, 8-bit.
  - Idle counter sized for TIMEOUT.
  - Gate counter sized for GATE_CYCLES.
- IDLE (BUSY=0, DUE=0, GATE=0): COIN is ignored. On VA:
  - H, M or L alone: `price` is set to the matching PRICE_x, `credit` to 0, the idle counter to 0, and the state goes to PAY.
  - E alone (exempt): goes to OPEN; no DUE, no CHG_V.
  - Zero bits or more than one bit set: VIOL pulses for one cycle and the state stays IDLE.
- PAY:
  - BUSY=1, DUE = `price` − `credit`.
  - On COIN, `credit` += value and the idle counter clears.
  - When the new `credit` ≥ `price`: go to OPEN, with CHG = `credit` − `price` and CHG_V=1 for exactly one cycle. CHG_V is asserted even when CHG = 0.
  - A cycle without COIN increments the idle counter.
  - When the counter reaches TIMEOUT−1 and no coin is present, the timeout fires:
    - VIOL=1 for one cycle.
    - CHG = `credit` (refund), and CHG_V=1 only if `credit` ≠ 0.
    - The gate stays closed and the state goes to IDLE.
  - VA is ignored in PAY.
- OPEN:
  - BUSY=1 and GATE=1 for exactly GATE_CYCLES cycles, then the state goes to IDLE.
  - VA and COIN are ignored.
- Width rule: `credit` before the final coin is less than `price` ≤ 155, so the maximum `credit` is 154 + 100 = 254, which fits in 8 bits with no saturation logic.
- CHG holds its last value when CHG_V=0.

## Timing

- Reset: on the RST edge, the state goes to IDLE and `credit`, `price` and both counters clear. All outputs read 0 from the following cycle.
- RST overrides every other input.
- A reset during PAY discards `credit`; no refund pulse is produced.
- Arrival: VA is sampled at edge N.
  - The cycle after N: BUSY=1 and DUE = price.
  - For an exempt vehicle, GATE=1 starting the cycle after N.
- Coin: COIN is sampled at edge N, and DUE reflects it the cycle after N.
- Final coin at edge N: the cycle after N has CHG_V=1, valid CHG and GATE=1 together. GATE then stays high for GATE_CYCLES cycles in total.
- Gate close: the first cycle with GATE=0 is IDLE, and a VA in that cycle is accepted.
- Timeout: with no coin, VIOL asserts TIMEOUT cycles after PAY entry or after the last accepted coin.
- Simultaneous events: a coin on the same edge as the timeout wins. The coin is credited and the timeout does not fire.
- CHG_V and VIOL never pulse on consecutive cycles for the same vehicle.

## Test plan

- M=1 VA, then coins 25, 25, 25 on consecutive cycles:
  - DUE reads 75 → 50 → 25.
  - Then CHG_V=1 with CHG=0, and GATE high for 16 cycles.
  - BUSY drops on the cycle GATE falls.
- H=1 VA, then coins 25 and 100: CHG_V=1 with CHG=25, then the gate opens.
- E=1 VA: GATE high 16 cycles starting the next cycle; CHG_V=0, VIOL=0, DUE=0 throughout.
- L=1 VA, one dime, then no coins:
  - VIOL=1, CHG_V=1, CHG=10 exactly 200 cycles after the dime.
  - GATE never rises and BUSY returns to 0.
- Invalid rate and ignored inputs:
  - VA with H=M=1: VIOL pulses for one cycle and BUSY stays 0.
  - VA with all rate bits 0: same response.
  - COIN in IDLE and VA during OPEN: no effect on any output.
- RST during PAY with `credit`=35:
  - Next cycle all outputs are 0 and there is no CHG_V pulse.
  - A following L=1 VA shows DUE=50.
